// File: rtl/uio_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module  : uio_cmd_decoder_if
// Brief   : HPS user-I/O command bus plus decoded configuration outputs.
// Rev     : 1.0  initial release
// ============================================================================
interface uio_cmd_decoder_if;
    logic        io_uio;
    logic        io_strobe;
    logic [15:0] io_din;
    logic [15:0] io_dout;
    logic [15:0] cfg;
    logic        cfg_ready;
    logic [31:0] status;
    logic        status_set;

    modport master (
        output io_uio, io_strobe, io_din,
        input  io_dout, cfg, cfg_ready, status, status_set
    );

    modport slave (
        input  io_uio, io_strobe, io_din,
        output io_dout, cfg, cfg_ready, status, status_set
    );
endinterface
`default_nettype wire

// File: rtl/uio_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module  : uio_cmd_decoder
// Brief   : Decodes the HPS user-I/O command stream into cfg/status/ID regs.
//           Optional macro UIO_STATUS_EN enables the SET_STATUS (0x02) command.
// Rev     : 1.0  initial release
// ============================================================================
module uio_cmd_decoder #(
    parameter logic [15:0] CORE_ID = 16'h00A4
) (
    input  wire logic        clk_sys,
    input  wire logic        reset,
    uio_cmd_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [7:0] C_CMD_SET_CFG = 8'h01;
    localparam logic [7:0] C_CMD_GET_ID  = 8'h04;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_old_strobe;
    logic [7:0]  r_cmd;
    logic [3:0]  r_wcnt;
    logic [15:0] r_io_dout;
    logic [15:0] r_cfg;
    logic        r_cfg_ready;
    logic        w_accept;
    logic        w_cmd_word;
    logic        w_data_word;

    assign w_accept    = bus.io_strobe & ~r_old_strobe & bus.io_uio;
    // A word arriving in the same cycle io_uio rises is still the command word.
    assign w_cmd_word  = w_accept & (r_state != S_DATA);
    assign w_data_word = w_accept & (r_state == S_DATA);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!bus.io_uio) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = w_accept ? S_DATA : S_CMD;
                S_CMD:   w_state_nxt = w_accept ? S_DATA : S_CMD;
                S_DATA:  w_state_nxt = S_DATA;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_old_strobe <= 1'b0;
            r_cmd        <= 8'h00;
            r_wcnt       <= 4'd0;
            r_io_dout    <= 16'h0000;
            r_cfg        <= 16'h0000;
            r_cfg_ready  <= 1'b0;
        end else begin
            r_old_strobe <= bus.io_strobe;
            if (!bus.io_uio) begin
                r_wcnt    <= 4'd0;
                r_io_dout <= 16'h0000;
            end else if (w_cmd_word) begin
                r_cmd     <= bus.io_din[7:0];
                r_wcnt    <= 4'd0;
                r_io_dout <= (bus.io_din[7:0] == C_CMD_GET_ID) ? CORE_ID : 16'h0000;
            end else if (w_data_word) begin
                if (r_wcnt != 4'hF) begin
                    r_wcnt <= r_wcnt + 4'd1;
                end
                if ((r_cmd == C_CMD_SET_CFG) && (r_wcnt == 4'd0)) begin
                    r_cfg       <= bus.io_din;
                    r_cfg_ready <= 1'b1;
                end
            end
        end
    end

    assign bus.io_dout   = r_io_dout;
    assign bus.cfg       = r_cfg;
    assign bus.cfg_ready = r_cfg_ready;

`ifdef UIO_STATUS_EN
    localparam logic [7:0] C_CMD_SET_STATUS = 8'h02;

    logic [15:0] r_status_lo;
    logic [31:0] r_status;
    logic        r_status_set;

    // Low half is only shadowed; status commits atomically on the second word.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_status_lo  <= 16'h0000;
            r_status     <= 32'h0000_0000;
            r_status_set <= 1'b0;
        end else begin
            r_status_set <= 1'b0;
            if (w_data_word && (r_cmd == C_CMD_SET_STATUS)) begin
                if (r_wcnt == 4'd0) begin
                    r_status_lo <= bus.io_din;
                end else if (r_wcnt == 4'd1) begin
                    r_status     <= {bus.io_din, r_status_lo};
                    r_status_set <= 1'b1;
                end
            end
        end
    end

    assign bus.status     = r_status;
    assign bus.status_set = r_status_set;
`else
    assign bus.status     = 32'h0000_0000;
    assign bus.status_set = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uio_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_uio_cmd_decoder
// Brief   : Scoreboard-based self-checking bench for uio_cmd_decoder.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uio_cmd_decoder;
    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    uio_cmd_decoder_if u_if ();

    uio_cmd_decoder u_dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (u_if.slave)
    );

    typedef struct {
        string       name;
        logic [64:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          pulses  = 0;
    int          p0;
    logic [15:0] m_cfg    = 16'h0;
    logic        m_rdy    = 1'b0;
    logic [31:0] m_status = 32'h0;
    logic [15:0] m_dout   = 16'h0;

    wire [64:0] w_obs = {u_if.io_dout, u_if.cfg, u_if.cfg_ready, u_if.status};

    always @(negedge clk_sys) if (u_if.status_set === 1'b1) pulses++;

    function automatic void push_exp(input string n);
        exp_t x;
        x.name = n;
        x.val  = {m_dout, m_cfg, m_rdy, m_status};
        sb.push_back(x);
    endfunction

    // Called at a negedge; returns at the negedge after the accepting clock edge.
    task automatic word(input logic [15:0] d);
        u_if.io_strobe = 1'b0;
        @(negedge clk_sys);
        u_if.io_din    = d;
        u_if.io_strobe = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic uio_on();
        u_if.io_uio = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic uio_off();
        u_if.io_uio    = 1'b0;
        u_if.io_strobe = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic test_reset();
        u_if.io_uio = 1'b0; u_if.io_strobe = 1'b0; u_if.io_din = 16'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        push_exp("reset_state");
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        n_tests++;
        if (u_if.status_set !== 1'b0) begin n_fail++; $display("FAIL reset_status_set: got %b expected 0", u_if.status_set); end
    endtask

    task automatic test_set_cfg();
        uio_on();
        push_exp("cfg_cmd_only");
        word(16'h0001);
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        m_cfg = 16'h0064; m_rdy = 1'b1;
        push_exp("cfg_set");
        word(16'h0064);
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        push_exp("cfg_extra_word_ignored");
        word(16'hFFFF);
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        uio_off();
    endtask

    task automatic test_set_status();
        p0 = pulses;
        uio_on();
        word(16'h0002);
        push_exp("status_after_lo");
        word(16'h5678);
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
`ifdef UIO_STATUS_EN
        m_status = 32'h1234_5678;
`endif
        push_exp("status_set");
        word(16'h1234);
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        uio_off();
        n_tests++;
`ifdef UIO_STATUS_EN
        if (pulses - p0 !== 1) begin n_fail++; $display("FAIL status_pulse_count: got %0d expected 1", pulses - p0); end
`else
        if (pulses - p0 !== 0) begin n_fail++; $display("FAIL status_pulse_count: got %0d expected 0", pulses - p0); end
`endif
    endtask

    task automatic test_abort_status();
        p0 = pulses;
        uio_on();
        word(16'h0002);
        word(16'hAAAA);
        uio_off();
        push_exp("status_abort_unchanged");
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        n_tests++;
        if (pulses - p0 !== 0) begin n_fail++; $display("FAIL abort_pulse_count: got %0d expected 0", pulses - p0); end
        uio_on();
        word(16'h0001);
        m_cfg = 16'h0020;
        push_exp("cfg_after_abort");
        word(16'h0020);
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        uio_off();
    endtask

    task automatic test_get_id();
        uio_on();
        m_dout = 16'h00A4;
        push_exp("id_on_cmd");
        word(16'hAB04);
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        for (int i = 0; i < 3; i++) begin
            push_exp($sformatf("id_held_%0d", i));
            word(16'h1111 * (i + 1));
            e = sb.pop_front(); n_tests++;
            if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        end
        u_if.io_uio = 1'b0; u_if.io_strobe = 1'b0;
        m_dout = 16'h0000;
        push_exp("id_cleared");
        @(negedge clk_sys);
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        @(negedge clk_sys);
        uio_on();
        push_exp("unknown_cmd_dout_zero");
        word(16'h0033);
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        uio_off();
    endtask

    task automatic test_strobe_hold();
        uio_on();
        u_if.io_strobe = 1'b0;
        @(negedge clk_sys);
        u_if.io_din = 16'h0001; u_if.io_strobe = 1'b1;
        push_exp("held_strobe_single_word");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            u_if.io_din = 16'h0BE0 + 16'(i);
        end
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        m_cfg = 16'h0077;
        push_exp("word_after_held_strobe");
        word(16'h0077);
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        uio_off();
    endtask

    task automatic test_abort_edge();
        uio_on();
        word(16'h0001);
        u_if.io_strobe = 1'b0;
        @(negedge clk_sys);
        u_if.io_din = 16'h0555; u_if.io_strobe = 1'b1; u_if.io_uio = 1'b0;
        push_exp("edge_with_uio_fall");
        @(negedge clk_sys);
        @(negedge clk_sys);
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        uio_off();
        uio_on();
        word(16'h0001);
        m_cfg = 16'h0033;
        push_exp("back_to_back_cmd");
        word(16'h0033);
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        uio_off();
    endtask

    task automatic test_reset_mid();
        uio_on();
        word(16'h0004);
        #1 reset = 1'b1;
        m_cfg = 16'h0; m_rdy = 1'b0; m_status = 32'h0; m_dout = 16'h0;
        push_exp("async_reset_mid");
        #1;
        e = sb.pop_front(); n_tests++;
        if (w_obs !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, w_obs, e.val); end
        u_if.io_uio = 1'b0; u_if.io_strobe = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
    endtask

    initial begin
        u_if.io_uio = 1'b0; u_if.io_strobe = 1'b0; u_if.io_din = 16'h0;
        test_reset();
        test_set_cfg();
        test_set_status();
        test_abort_status();
        test_get_id();
        test_strobe_hold();
        test_abort_edge();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
